// File: rtl/sisc_mem_pkg.sv
// rtl/sisc_mem_pkg.sv - shared encodings and default widths for the SISC memory arbiter
// Contents: FSM state encoding, access owner encoding, default address/data widths.
package sisc_mem_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational winner select between fetch and data requesters
// Ports:
//   i_if_req    fetch request
//   i_d_req     data request
//   i_wait_cnt  consecutive data grants made while fetch was waiting
//   o_grant     some requester wins this cycle
//   o_owner     winning requester (meaningful only when o_grant=1)
module mem_arb_pick
    import sisc_mem_pkg::*;
#(
    parameter int MAX_WAIT = 2,
    parameter int WAIT_W   = 2
) (
    input  logic              i_if_req,
    input  logic              i_d_req,
    input  logic [WAIT_W-1:0] i_wait_cnt,
    output logic              o_grant,
    output owner_t            o_owner
);

    logic w_fetch_starved;

    // Fetch has waited through MAX_WAIT data grants; with MAX_WAIT=0 this is
    // always true, so fetch wins every contested cycle.
    assign w_fetch_starved = (i_wait_cnt == WAIT_W'(MAX_WAIT));

    always_comb begin
        o_grant = i_if_req | i_d_req;
        o_owner = OWN_IF;
        if (i_d_req && !(i_if_req && w_fetch_starved)) begin
            o_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - single-port memory arbiter/sequencer for instruction fetch and data access
// Ports:
//   clk, rst_f                    clock (rising edge), asynchronous active-low reset
//   if_req/if_addr                fetch request and address
//   if_rdata/if_done              fetched word (registered) and completion pulse
//   d_req/d_we/d_addr/d_wdata     data request: store when d_we=1, load otherwise
//   d_rdata/d_done                loaded word (registered) and completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory side, held stable per access
//   busy                          FSM is not idle
module mem_arb
    import sisc_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 2
) (
    input  logic              clk,
    input  logic              rst_f,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int LAT_W  = $clog2(MEM_LAT + 1);
    localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

    state_t              r_state;
    state_t              w_next_state;
    owner_t              r_owner;
    logic [LAT_W-1:0]    r_lat_cnt;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_if_done;
    logic                r_d_done;

    logic                w_grant;
    owner_t              w_owner;
    logic                w_last;

    mem_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_pick (
        .i_if_req   (if_req),
        .i_d_req    (d_req),
        .i_wait_cnt (r_wait_cnt),
        .o_grant    (w_grant),
        .o_owner    (w_owner)
    );

    // Final cycle of the access: the edge that ends it captures read data.
    assign w_last = (r_state == ST_ACCESS) && (r_lat_cnt == LAT_W'(1));

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_grant) w_next_state = ST_ACCESS;
            ST_ACCESS: if (w_last)  w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_owner     <= OWN_IF;
            r_lat_cnt   <= '0;
            r_wait_cnt  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_owner  <= w_owner;
                        r_mem_en <= 1'b1;
                        if (w_owner == OWN_D) begin
                            r_mem_addr  <= d_addr;
                            r_mem_wdata <= d_wdata;
                            r_mem_we    <= d_we;
                            r_lat_cnt   <= d_we ? LAT_W'(1) : LAT_W'(MEM_LAT);
                        end else begin
                            r_mem_addr  <= if_addr;
                            r_mem_wdata <= '0;
                            r_mem_we    <= 1'b0;
                            r_lat_cnt   <= LAT_W'(MEM_LAT);
                        end
                    end
                    // Starvation counter only tracks data grants that pass over
                    // a waiting fetch; anything else resets the streak.
                    if (!if_req || (w_owner == OWN_IF)) begin
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt != WAIT_W'(MAX_WAIT)) begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ACCESS: begin
                    r_lat_cnt <= r_lat_cnt - LAT_W'(1);
                    if (w_last) begin
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= mem_rdata;
                            r_if_done  <= 1'b1;
                        end else begin
                            if (!r_mem_we) r_d_rdata <= mem_rdata;
                            r_d_done <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_done   = r_if_done;
    assign d_rdata   = r_d_rdata;
    assign d_done    = r_d_done;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb with directed scenarios and a transaction-level model
module tb_mem_arb;

    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int MEM_LAT  = 2;
    localparam int MAX_WAIT = 2;

    logic              clk = 1'b0;
    logic              rst_f = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    logic [DATA_W-1:0] mem_arr [0:255];

    int n_checks = 0;
    int n_err    = 0;

    // transaction-level reference model state
    int                m_left;
    int                m_wait;
    bit                m_own_d;
    bit                m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_if_rdata;
    logic [DATA_W-1:0] m_d_rdata;

    mem_arb #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MEM_LAT  (MEM_LAT),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk       (clk),
        .rst_f     (rst_f),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    assign mem_rdata = mem_arr[mem_addr[7:0]];

    always #5 clk = ~clk;

    task automatic test_reset();
        rst_f = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if ({mem_en, mem_we, if_done, d_done, busy} !== 5'b0) begin n_err++; $display("FAIL reset_flags got=%b exp=00000", {mem_en, mem_we, if_done, d_done, busy}); end
        n_checks++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        n_checks++; if (mem_wdata !== '0) begin n_err++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        n_checks++; if (if_rdata !== '0 || d_rdata !== '0) begin n_err++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
        rst_f = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_fetch_only();
        if_req = 1'b1; if_addr = 16'h0010; d_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c <= 2) begin
                n_checks++; if ({mem_en, mem_we, if_done} !== 3'b100) begin n_err++; $display("FAIL fetch_access c=%0d got en/we/done=%b exp=100", c, {mem_en, mem_we, if_done}); end
                n_checks++; if (mem_addr !== 16'h0010) begin n_err++; $display("FAIL fetch_addr c=%0d got=%h exp=0010", c, mem_addr); end
            end else if (c == 3) begin
                n_checks++; if ({mem_en, if_done, busy} !== 3'b011) begin n_err++; $display("FAIL fetch_done got en/done/busy=%b exp=011", {mem_en, if_done, busy}); end
                n_checks++; if (if_rdata !== 32'h81200003) begin n_err++; $display("FAIL fetch_rdata got=%h exp=81200003", if_rdata); end
                if_req = 1'b0;
            end else begin
                n_checks++; if ({if_done, busy} !== 2'b00) begin n_err++; $display("FAIL fetch_after got done/busy=%b exp=00", {if_done, busy}); end
            end
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #2 rst_f = 1'b0;
        #1;
        n_checks++; if (if_rdata !== '0 || mem_addr !== '0) begin n_err++; $display("FAIL async_reset_regs got if_rdata=%h mem_addr=%h exp=0", if_rdata, mem_addr); end
        n_checks++; if ({mem_en, mem_we, if_done, d_done, busy} !== 5'b0) begin n_err++; $display("FAIL async_reset_flags got=%b exp=00000", {mem_en, mem_we, if_done, d_done, busy}); end
        @(negedge clk);
        rst_f = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_simultaneous();
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0100; d_wdata = 32'hDEADBEEF;
        if_req = 1'b1; if_addr = 16'h0011;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            case (c)
                1: begin
                    n_checks++; if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 16'h0100 || mem_wdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL simul_store got en/we=%b addr=%h wdata=%h exp=11 0100 deadbeef", {mem_en, mem_we}, mem_addr, mem_wdata); end
                end
                2: begin
                    n_checks++; if ({d_done, if_done, mem_en} !== 3'b100) begin n_err++; $display("FAIL simul_d_done got d/if/en=%b exp=100", {d_done, if_done, mem_en}); end
                    n_checks++; if (d_rdata !== '0) begin n_err++; $display("FAIL simul_store_keeps_rdata got=%h exp=0", d_rdata); end
                    d_req = 1'b0; d_we = 1'b0;
                end
                3: begin
                    n_checks++; if (busy !== 1'b0) begin n_err++; $display("FAIL simul_idle_gap got busy=%b exp=0", busy); end
                end
                4, 5: begin
                    n_checks++; if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 16'h0011) begin n_err++; $display("FAIL simul_fetch c=%0d got en/we=%b addr=%h exp=10 0011", c, {mem_en, mem_we}, mem_addr); end
                end
                6: begin
                    n_checks++; if (if_done !== 1'b1 || if_rdata !== mem_arr[8'h11]) begin n_err++; $display("FAIL simul_if_done got done=%b rdata=%h exp=1 %h", if_done, if_rdata, mem_arr[8'h11]); end
                    if_req = 1'b0;
                end
                default: begin
                    n_checks++; if ({if_done, d_done, busy} !== 3'b000) begin n_err++; $display("FAIL simul_end got=%b exp=000", {if_done, d_done, busy}); end
                end
            endcase
        end
    endtask

    task automatic test_starvation();
        string got;
        string exp_order;
        exp_order = "DDFDDF";
        got = "";
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0030;
        if_req = 1'b1; if_addr = 16'h0012;
        for (int c = 0; c < 60 && got.len() < 6; c++) begin
            @(negedge clk);
            if (d_done) got = {got, "D"};
            if (if_done) got = {got, "F"};
        end
        d_req = 1'b0; if_req = 1'b0;
        n_checks++; if (got != exp_order) begin n_err++; $display("FAIL starvation_order got=%s exp=%s", got, exp_order); end
        n_checks++; if (d_rdata !== mem_arr[8'h30]) begin n_err++; $display("FAIL starvation_d_rdata got=%h exp=%h", d_rdata, mem_arr[8'h30]); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        int lat;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0040;
        @(posedge clk);
        #2 rst_f = 1'b0;
        #1;
        n_checks++; if ({mem_en, mem_we, busy} !== 3'b000 || d_rdata !== '0) begin n_err++; $display("FAIL midread_reset got en/we/busy=%b d_rdata=%h exp=000 0", {mem_en, mem_we, busy}, d_rdata); end
        @(negedge clk);
        n_checks++; if (d_done !== 1'b0) begin n_err++; $display("FAIL midread_no_done got=%b exp=0", d_done); end
        rst_f = 1'b1;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (d_done) lat = c;
        end
        d_req = 1'b0;
        n_checks++; if (lat != MEM_LAT + 1) begin n_err++; $display("FAIL midread_retry_latency got=%0d exp=%0d", lat, MEM_LAT + 1); end
        n_checks++; if (d_rdata !== mem_arr[8'h40]) begin n_err++; $display("FAIL midread_retry_rdata got=%h exp=%h", d_rdata, mem_arr[8'h40]); end
        @(negedge clk);
    endtask

    task automatic test_req_drop();
        int en_cycles;
        int dones;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
        en_cycles = 0; dones = 0;
        @(negedge clk);
        d_req = 1'b0;
        if (mem_en) en_cycles++;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (mem_en) en_cycles++;
            if (d_done) dones++;
        end
        n_checks++; if (dones != 1) begin n_err++; $display("FAIL drop_done_count got=%0d exp=1", dones); end
        n_checks++; if (en_cycles != MEM_LAT) begin n_err++; $display("FAIL drop_en_cycles got=%0d exp=%0d", en_cycles, MEM_LAT); end
        n_checks++; if (d_rdata !== mem_arr[8'h50]) begin n_err++; $display("FAIL drop_rdata got=%h exp=%h", d_rdata, mem_arr[8'h50]); end
    endtask

    task automatic test_random();
        rst_f = 1'b0; if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        rst_f = 1'b1;
        m_left = 0; m_wait = 0; m_own_d = 1'b0; m_we = 1'b0;
        m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_d_rdata = '0;
        for (int i = 0; i < 400; i++) begin
            n_checks++; if (busy !== (m_left > 0)) begin n_err++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, busy, m_left > 0); end
            n_checks++; if (if_done !== (m_left == 1 && !m_own_d) || d_done !== (m_left == 1 && m_own_d)) begin n_err++; $display("FAIL rnd_done i=%0d got if/d=%b%b exp=%b%b", i, if_done, d_done, m_left == 1 && !m_own_d, m_left == 1 && m_own_d); end
            n_checks++; if (mem_en !== (m_left > 1)) begin n_err++; $display("FAIL rnd_mem_en i=%0d got=%b exp=%b", i, mem_en, m_left > 1); end
            if (m_left > 1) begin
                n_checks++; if (mem_addr !== m_addr || mem_we !== m_we || (m_we && mem_wdata !== m_wdata)) begin n_err++; $display("FAIL rnd_mem_bus i=%0d got addr=%h we=%b wdata=%h exp=%h %b %h", i, mem_addr, mem_we, mem_wdata, m_addr, m_we, m_wdata); end
            end
            n_checks++; if (if_rdata !== m_if_rdata || d_rdata !== m_d_rdata) begin n_err++; $display("FAIL rnd_rdata i=%0d got=%h/%h exp=%h/%h", i, if_rdata, d_rdata, m_if_rdata, m_d_rdata); end

            // requesters: hold until done, then maybe reissue immediately
            if (m_left == 1 && m_own_d) d_req = 1'($urandom % 2);
            else if (!d_req) d_req = ($urandom % 3 == 0);
            if (m_left == 1 && !m_own_d) if_req = 1'($urandom % 2);
            else if (!if_req) if_req = ($urandom % 3 == 0);
            if_addr = 16'($urandom); d_addr = 16'($urandom);
            d_wdata = $urandom; d_we = 1'($urandom % 2);

            // model the upcoming clock edge
            if (m_left == 0) begin
                if (d_req && (!if_req || m_wait < MAX_WAIT)) begin
                    m_own_d = 1'b1; m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                    m_left = (d_we ? 1 : MEM_LAT) + 1;
                    m_wait = if_req ? m_wait + 1 : 0;
                end else if (if_req) begin
                    m_own_d = 1'b0; m_we = 1'b0; m_addr = if_addr;
                    m_left = MEM_LAT + 1;
                    m_wait = 0;
                end else begin
                    m_wait = 0;
                end
            end else begin
                m_left--;
                if (m_left == 1 && !m_we) begin
                    if (m_own_d) m_d_rdata = mem_arr[m_addr[7:0]];
                    else m_if_rdata = mem_arr[m_addr[7:0]];
                end
            end
            @(negedge clk);
        end
        if_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
        mem_arr[8'h10] = 32'h81200003;
        test_reset();
        test_fetch_only();
        test_async_reset();
        test_simultaneous();
        test_starvation();
        test_reset_mid_read();
        test_req_drop();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
